// File: rtl/tester_pkg.sv
// -----------------------------------------------------------------------------
// tester_pkg
//   Definitions shared by the tester vector engine and the pin driver:
//   pin-driver state encoding and the DUT-input synchroniser depth.
// -----------------------------------------------------------------------------
package tester_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;  // waiting for a vector request
  localparam state_t SWITCH  = 2'd1;  // guard interval, pins released
  localparam state_t SETTLE  = 2'd2;  // stimulus driven, waiting to sample
  localparam state_t RESPOND = 2'd3;  // response offered to the tester

  // Depth of the synchroniser on asynchronous DUT outputs.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Multi-bit flop-chain synchroniser for asynchronous DUT outputs. Each bit is
//   synchronised independently; the bus is only meaningful when the source is
//   stable for longer than the chain latency.
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low reset, clears every stage
//   d       - asynchronous input bus
//   q       - synchronised output, SYNC_STAGES cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff
  import tester_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the value its predecessor held before the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/dut_pin_driver.sv
// -----------------------------------------------------------------------------
// dut_pin_driver
//   Pin-level stage between the tester vector engine and the device under test.
//   Accepts one vector at a time, guards target changes with the pins released,
//   drives the stimulus, waits a programmable settle time and returns the
//   synchronised DUT response over a valid/ready handshake.
// Ports:
//   clock, reset_n          - system clock, asynchronous active-low reset
//   abort                   - tester disabled; cancels any transaction
//   req_valid/req_ready     - vector request handshake
//   req_mosi/target/wait    - stimulus, target select, extra settle cycles
//   rsp_valid/rsp_ready     - response handshake, rsp_miso is the sample
//   busy                    - high whenever not idle
//   target_sel, mosi, pin_oe- registered board-side pin controls
//   miso                    - asynchronous DUT outputs
// -----------------------------------------------------------------------------
module dut_pin_driver
  import tester_pkg::*;
#(
  parameter int PIN_WIDTH    = 24,
  parameter int SEL_WIDTH    = 5,
  parameter int WAIT_WIDTH   = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  abort,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PIN_WIDTH-1:0]  req_mosi,
  input  logic [SEL_WIDTH-1:0]  req_target,
  input  logic [WAIT_WIDTH-1:0] req_wait,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PIN_WIDTH-1:0]  rsp_miso,
  output logic                  busy,
  output logic [SEL_WIDTH-1:0]  target_sel,
  output logic [PIN_WIDTH-1:0]  mosi,
  output logic                  pin_oe,
  input  logic [PIN_WIDTH-1:0]  miso
);

  // One extra bit so req_wait + 2 never wraps at the maximum wait.
  localparam int CNT_W = WAIT_WIDTH + 1;

  state_t                state_q,      state_d;
  logic                  target_set_q, target_set_d;
  logic [SEL_WIDTH-1:0]  target_sel_q, target_sel_d;
  logic [PIN_WIDTH-1:0]  mosi_q,       mosi_d;
  logic                  pin_oe_q,     pin_oe_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [PIN_WIDTH-1:0]  rsp_miso_q,   rsp_miso_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [PIN_WIDTH-1:0]  vec_q,        vec_d;
  logic [WAIT_WIDTH-1:0] wait_q,       wait_d;

  logic [PIN_WIDTH-1:0]  miso_sync;
  logic                  accept;

  sync_2ff #(.WIDTH(PIN_WIDTH)) u_miso_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (miso),
    .q       (miso_sync)
  );

  assign req_ready = (state_q == IDLE) && !abort;
  assign accept    = req_valid && req_ready;

  always_comb begin
    // NOTE: every signal gets a hold default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    target_set_d = target_set_q;
    target_sel_d = target_sel_q;
    mosi_d       = mosi_q;
    pin_oe_d     = pin_oe_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_miso_d   = rsp_miso_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    wait_d       = wait_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d  = req_mosi;
          wait_d = req_wait;
          if (!target_set_q || (req_target != target_sel_q)) begin
            state_d      = SWITCH;
            target_sel_d = req_target;
            mosi_d       = '0;
            pin_oe_d     = 1'b0;
            target_set_d = 1'b1;
            // Counts down to 0 so SWITCH lasts exactly GUARD_CYCLES cycles.
            cnt_d        = CNT_W'(GUARD_CYCLES - 1);
          end else begin
            state_d  = SETTLE;
            mosi_d   = req_mosi;
            pin_oe_d = 1'b1;
            cnt_d    = CNT_W'(req_wait) + CNT_W'(2);
          end
        end
      end
      SWITCH: begin
        if (cnt_q == '0) begin
          state_d  = SETTLE;
          mosi_d   = vec_q;
          pin_oe_d = 1'b1;
          cnt_d    = CNT_W'(wait_q) + CNT_W'(2);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        // The +2 loaded on entry covers the synchroniser latency, so the sample
        // taken at 0 reflects the stimulus driven on entry.
        if (cnt_q == '0) begin
          state_d     = RESPOND;
          rsp_miso_d  = miso_sync;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks everything and forces the next request to re-guard.
    if (abort) begin
      state_d      = IDLE;
      pin_oe_d     = 1'b0;
      mosi_d       = '0;
      rsp_valid_d  = 1'b0;
      target_set_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      target_set_q <= 1'b0;
      target_sel_q <= '0;
      mosi_q       <= '0;
      pin_oe_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_miso_q   <= '0;
      cnt_q        <= '0;
      vec_q        <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      target_set_q <= target_set_d;
      target_sel_q <= target_sel_d;
      mosi_q       <= mosi_d;
      pin_oe_q     <= pin_oe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_miso_q   <= rsp_miso_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      wait_q       <= wait_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign target_sel = target_sel_q;
  assign mosi       = mosi_q;
  assign pin_oe     = pin_oe_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_miso   = rsp_miso_q;

endmodule

// File: doc/dut_pin_driver.md
# dut_pin_driver

Pin-level stage between the `tester` vector engine and the device under test. It accepts one test vector per request and selects the target. When the target changes it passes through a guard interval with the pins released. It then drives the stimulus, waits a programmable settle time, and samples the synchronised DUT response. The sampled response goes back to the tester over a valid/ready handshake. It replaces the direct `mosi`/`miso`/`target_sel` wiring in `de2115sys`.

## Interface
Parameters:
- `PIN_WIDTH`, 24, stimulus/response vector width
- `SEL_WIDTH`, 5, target select width
- `WAIT_WIDTH`, 16, settle-count width
- `GUARD_CYCLES`, 4, cycles with pins released on a target change (≥1)

Ports:
- `clock`  in  1  system clock (100 MHz domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `abort`  in  1  tester disabled; cancels any transaction
- `req_valid`  in  1  vector request valid
- `req_ready`  out  1  request accepted when high together with `req_valid`
- `req_mosi`  in  PIN_WIDTH  stimulus vector
- `req_target`  in  SEL_WIDTH  target for this vector
- `req_wait`  in  WAIT_WIDTH  extra settle cycles
- `rsp_valid`  out  1  response valid, held until accepted
- `rsp_ready`  in  1  tester accepts response
- `rsp_miso`  out  PIN_WIDTH  sampled DUT response
- `busy`  out  1  state ≠ IDLE
- `target_sel`  out  SEL_WIDTH  registered target select to the board
- `mosi`  out  PIN_WIDTH  registered stimulus pins
- `pin_oe`  out  1  pin output enable
- `miso`  in  PIN_WIDTH  asynchronous DUT outputs

## Operation
- **States:**
  - IDLE → SWITCH: on acceptance when `req_target` ≠ the held target, or when no target has been set since reset.
  - IDLE → SETTLE: on acceptance otherwise.
  - SWITCH → SETTLE: after `GUARD_CYCLES` cycles.
  - SETTLE → RESPOND: when the counter reaches 0.
  - RESPOND → IDLE: when `rsp_ready` is high.
- `req_ready` = (state == IDLE) && !`abort`.
- On acceptance, register `req_mosi`, `req_target` and `req_wait`.
- **Entering SWITCH:**
  - `target_sel` ← new target; `mosi` ← 0; `pin_oe` ← 0.
  - Set the target-set flag.
- **Entering SETTLE:**
  - `mosi` ← stored vector; `pin_oe` ← 1.
  - Counter ← `req_wait` + 2 (width `WAIT_WIDTH`+1, so no overflow at the maximum).
- **In SETTLE:**
  - Counter decrements each cycle.
  - At 0, `rsp_miso` ← the synchronised `miso`, and `rsp_valid` ← 1.
- `miso` passes through a 2-flop synchroniser; the +2 in the counter covers its latency.
- `mosi`, `pin_oe` and `target_sel` hold their values in RESPOND and IDLE. Pins stay driven between vectors on the same target.
- **`abort`, in any state (highest priority):**
  - Next state IDLE; `pin_oe` ← 0; `mosi` ← 0; `rsp_valid` ← 0.
  - The target-set flag is cleared, so the next request re-guards.
  - `abort` together with `req_valid` in IDLE: the request is not accepted.
- A new request is accepted only in IDLE, so there is one transaction in flight.

## Timing
- Acceptance edge ends cycle T.
- Same target: `mosi`/`pin_oe` are valid from T+1; `rsp_valid` is high from T+`req_wait`+4.
- Target change: `target_sel` is valid from T+1 and `mosi` from T+`GUARD_CYCLES`+1; `rsp_valid` is high from T+`GUARD_CYCLES`+`req_wait`+4.
- Back-to-back throughput: the response cycle plus one IDLE cycle is the minimum gap before the next acceptance.
- **Reset values (asynchronous):**
  - State IDLE; target-set flag 0.
  - `target_sel`, `mosi`, `pin_oe`, `rsp_valid`, `rsp_miso`, `busy` = 0.
  - Synchroniser flops = 0.
  - `req_ready` = 1 once `reset_n` is high and `abort` is low.
- Reset mid-transaction: all outputs return to their reset values immediately. There is no response for the lost vector.

## Structure
- `tester_pkg`: state encoding localparams (IDLE, SWITCH, SETTLE, RESPOND) and the synchroniser depth constant `SYNC_STAGES` = 2, shared with `tester`.
- Sub-module `sync_2ff` (parameterised width, `clock`/`reset_n`) for `miso`; it is reused later for other DUT inputs.

## Test plan
- **Same target, zero wait:** with `PIN_WIDTH`=24, first set target 3, then send `req_mosi`=0x000001, `req_wait`=0, target 3, with DUT modelled as `miso` = `mosi` << 1 → `rsp_miso`=0x000002 and `rsp_valid` at T+4.
- **First request after reset:** target 0, `req_wait`=5 → SWITCH for 4 cycles with `pin_oe`=0 and `mosi`=0; `rsp_valid` at T+13.
- **Target change:** 3 → 7 → `target_sel`=7 at T+1; `pin_oe` low for exactly 4 cycles; `mosi` 0 during the guard.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_miso` stable, `req_ready`=0 throughout; accepted on the first cycle `rsp_ready` is high.
- **Abort in SETTLE with `req_wait`=0xFFFF:** → IDLE next cycle, `pin_oe`=0, no `rsp_valid`; the next request to the same target still goes through SWITCH.
- **`reset_n` low during RESPOND:** all outputs are 0 asynchronously; after release `req_ready`=1 and the first request guards.
